// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb
// Arbitrates the single register-file write port between the WB stage and a
// long-latency unit (mul/div/uncached load). It also keeps a 32-entry busy
// scoreboard for decode hazard detection.
//
// Write priority: WB > buffered long-latency result (FIFO head) > direct
// long-latency bypass. If a long-latency result loses to WB, it is parked in
// a small FIFO of DEPTH entries. The FIFO head retires on the first cycle
// that WB leaves the port free.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   wb_w_rd/wb_rd/wb_res      WB write request (never stalls)
//   lu_valid/lu_rd/lu_res     long-latency result offer
//   lu_ready                  result accepted this cycle (count < DEPTH)
//   sb_set/sb_rd              long-latency issue: mark sb_rd busy
//   chk_rs1/chk_rs2/chk_rd    decode register numbers for hazard check
//   hazard                    decode touches a busy register
//   rf_we/rf_waddr/rf_wdata   register file write port
//   drain_req                 FIFO full; front end must insert bubbles
module regfile_wr_arb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_w_rd,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_res,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_res,
    output logic        lu_ready,
    input  logic        sb_set,
    input  logic [4:0]  sb_rd,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    input  logic [4:0]  chk_rd,
    output logic        hazard,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        drain_req
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // FIFO state. Pointers are exactly AW bits wide and DEPTH is a power of
    // two, so they wrap modulo DEPTH with no extra logic.
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [4:0]    buf_rd   [DEPTH];
    logic [31:0]   buf_data [DEPTH];

    logic [31:0]   busy_reg;
    logic [31:0]   busy_next;

    logic          fifo_empty;
    logic          pop;
    logic          bypass;
    logic          push;
    logic          commit;
    logic [4:0]    commit_rd;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    assign fifo_empty = (count_reg == '0);
    assign head_rd    = buf_rd[rd_ptr_reg];
    assign head_data  = buf_data[rd_ptr_reg];

    // lu_ready looks only at the registered count, so the unit can see it
    // before it decides to offer a result. The rst term holds lu_ready low
    // while reset is asserted, even though the count is already zero then.
    assign lu_ready  = ~rst & (count_reg < FULL);
    assign drain_req = ~rst & (count_reg == FULL);

    assign pop    = ~wb_w_rd & ~fifo_empty;
    assign bypass = ~wb_w_rd & fifo_empty & lu_valid;
    assign push   = lu_valid & lu_ready & ~bypass;

    // A long-latency result has committed when it reaches the register file,
    // either from the FIFO head or through the bypass path.
    assign commit    = pop | bypass;
    assign commit_rd = pop ? head_rd : lu_rd;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!rst) begin
            if (wb_w_rd) begin
                rf_we    = 1'b1;
                rf_waddr = wb_rd;
                rf_wdata = wb_res;
            end else if (!fifo_empty) begin
                rf_we    = 1'b1;
                rf_waddr = head_rd;
                rf_wdata = head_data;
            end else if (lu_valid) begin
                rf_we    = 1'b1;
                rf_waddr = lu_rd;
                rf_wdata = lu_res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Storage needs no reset. Resetting the pointers and count makes any
    // stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_rd[wr_ptr_reg]   <= lu_rd;
            buf_data[wr_ptr_reg] <= lu_res;
        end
    end

    // Scoreboard. If the same register is issued and committed in one cycle,
    // the issue wins: the new op is still outstanding. A WB write never
    // changes busy state.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_busy
            assign busy_next[gi] = (sb_set && (sb_rd == 5'(gi)))        ? 1'b1 :
                                   (commit && (commit_rd == 5'(gi)))    ? 1'b0 :
                                   busy_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign hazard = ~rst & (busy_reg[chk_rs1] | busy_reg[chk_rs2] | busy_reg[chk_rd]);

endmodule

// File: tb/tb_regfile_wr_arb.sv
module tb_regfile_wr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_w_rd;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_res;
    logic        lu_ready;
    logic        sb_set;
    logic [4:0]  sb_rd;
    logic [4:0]  chk_rs1, chk_rs2, chk_rd;
    logic        hazard;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        drain_req;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_wr_arb #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .wb_w_rd(wb_w_rd), .wb_rd(wb_rd), .wb_res(wb_res),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_res(lu_res), .lu_ready(lu_ready),
        .sb_set(sb_set), .sb_rd(sb_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .drain_req(drain_req)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Inputs change on the falling edge. Outputs are sampled 1 ns later,
    // well before the next rising edge.
    task automatic next_cycle();
        @(negedge clk);
        wb_w_rd = 0; wb_rd = 0; wb_res = 0;
        lu_valid = 0; lu_rd = 0; lu_res = 0;
        sb_set = 0; sb_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1;
        wb_w_rd = 1; wb_rd = 4; wb_res = 32'h55;
        lu_valid = 0; lu_rd = 0; lu_res = 0;
        sb_set = 0; sb_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
        @(negedge clk); settle();
        check_val("rst_rf_we", rf_we, 0);
        check_val("rst_lu_ready", lu_ready, 0);
        check_val("rst_hazard", hazard, 0);
        check_val("rst_drain", drain_req, 0);

        // Release reset: the FIFO is empty and ready.
        next_cycle(); rst = 0; settle();
        check_val("post_rst_lu_ready", lu_ready, 1);
        check_val("post_rst_drain", drain_req, 0);
        check_val("post_rst_rf_we", rf_we, 0);

        // WB-only write.
        next_cycle(); wb_w_rd = 1; wb_rd = 5; wb_res = 32'h11; settle();
        check_val("wb_we", rf_we, 1);
        check_val("wb_waddr", rf_waddr, 5);
        check_val("wb_wdata", rf_wdata, 32'h11);

        // Bypass: the result goes straight to the register file with no push.
        next_cycle(); lu_valid = 1; lu_rd = 7; lu_res = 32'hAB; settle();
        check_val("byp_we", rf_we, 1);
        check_val("byp_waddr", rf_waddr, 7);
        check_val("byp_wdata", rf_wdata, 32'hAB);
        check_val("byp_lu_ready", lu_ready, 1);
        next_cycle(); settle();
        check_val("byp_no_push_we", rf_we, 0);

        // Scoreboard: set, then clear on a bypass commit.
        next_cycle(); sb_set = 1; sb_rd = 9; chk_rs1 = 9; settle();
        check_val("sb_hazard_same_cycle", hazard, 0);
        next_cycle(); chk_rs1 = 9; settle();
        check_val("sb_hazard_rs1", hazard, 1);
        next_cycle(); chk_rs2 = 9; lu_valid = 1; lu_rd = 9; lu_res = 32'h99; settle();
        check_val("sb_hazard_commit_cycle", hazard, 1);
        check_val("sb_commit_waddr", rf_waddr, 9);
        next_cycle(); chk_rs1 = 9; settle();
        check_val("sb_hazard_cleared", hazard, 0);
        // When set and commit hit the same register in one cycle, set wins.
        next_cycle(); sb_set = 1; sb_rd = 9;
        next_cycle(); sb_set = 1; sb_rd = 9; lu_valid = 1; lu_rd = 9; lu_res = 32'h9;
        next_cycle(); chk_rd = 9; settle();
        check_val("sb_set_wins", hazard, 1);
        next_cycle(); lu_valid = 1; lu_rd = 9; lu_res = 32'h9;
        next_cycle(); chk_rd = 9; settle();
        check_val("sb_final_clear", hazard, 0);

        // Conflict and fill. busy[2] is set here so the later pop of rd2 can be
        // seen clearing it.
        next_cycle(); wb_w_rd = 1; wb_rd = 20; wb_res = 32'h200;
        lu_valid = 1; lu_rd = 1; lu_res = 32'h101; sb_set = 1; sb_rd = 2; settle();
        check_val("fill1_waddr", rf_waddr, 20);
        check_val("fill1_lu_ready", lu_ready, 1);
        next_cycle(); wb_w_rd = 1; wb_rd = 21; wb_res = 32'h210;
        lu_valid = 1; lu_rd = 2; lu_res = 32'h102; settle();
        check_val("fill2_lu_ready", lu_ready, 1);
        check_val("fill2_drain", drain_req, 0);
        next_cycle(); wb_w_rd = 1; wb_rd = 22; wb_res = 32'h220;
        lu_valid = 1; lu_rd = 3; lu_res = 32'h103; settle();
        check_val("fill3_lu_ready", lu_ready, 0);
        check_val("fill3_drain", drain_req, 1);
        check_val("fill3_waddr", rf_waddr, 22);
        // WB releases the port: the FIFO drains in order while rd3 is still held.
        next_cycle(); lu_valid = 1; lu_rd = 3; lu_res = 32'h103; settle();
        check_val("drain1_waddr", rf_waddr, 1);
        check_val("drain1_wdata", rf_wdata, 32'h101);
        check_val("drain1_lu_ready", lu_ready, 0);
        // Pop and push in the same cycle at count=1, across the pointer wrap.
        next_cycle(); lu_valid = 1; lu_rd = 3; lu_res = 32'h103; chk_rs2 = 2; settle();
        check_val("drain2_waddr", rf_waddr, 2);
        check_val("drain2_wdata", rf_wdata, 32'h102);
        check_val("drain2_lu_ready", lu_ready, 1);
        check_val("drain2_hazard", hazard, 1);
        next_cycle(); chk_rs2 = 2; settle();
        check_val("drain3_we", rf_we, 1);
        check_val("drain3_waddr", rf_waddr, 3);
        check_val("drain3_wdata", rf_wdata, 32'h103);
        check_val("pop_clear_hazard", hazard, 0);
        next_cycle(); settle();
        check_val("drained_we", rf_we, 0);
        check_val("drained_drain", drain_req, 0);

        // Async reset with count=2 and busy[3]=1.
        next_cycle(); wb_w_rd = 1; wb_rd = 10; lu_valid = 1; lu_rd = 11; lu_res = 32'hB1;
        sb_set = 1; sb_rd = 3;
        next_cycle(); wb_w_rd = 1; wb_rd = 10; lu_valid = 1; lu_rd = 12; lu_res = 32'hB2;
        next_cycle(); wb_w_rd = 1; wb_rd = 10; chk_rs1 = 3; settle();
        check_val("pre_rst_drain", drain_req, 1);
        check_val("pre_rst_hazard", hazard, 1);
        rst = 1; #1;
        check_val("arst_rf_we", rf_we, 0);
        check_val("arst_lu_ready", lu_ready, 0);
        check_val("arst_hazard", hazard, 0);
        check_val("arst_drain", drain_req, 0);
        next_cycle(); rst = 0; chk_rs1 = 3; settle();
        check_val("rel_rf_we", rf_we, 0);
        check_val("rel_lu_ready", lu_ready, 1);
        check_val("rel_hazard", hazard, 0);
        next_cycle(); settle();
        check_val("rel2_rf_we", rf_we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
